// File: rtl/mm_regs_arbiter.sv
// mm_regs_arbiter: round-robin arbiter sharing one register-bridge Avalon-MM slave among NUM_MASTERS masters.
// Define MM_ARB_TIMEOUT_EN to force-complete reads that stall in RESP for RESP_TIMEOUT cycles.
module mm_regs_arbiter #(
    parameter int NUM_MASTERS  = 2,
    parameter int ADDR_SIZE    = 4,
    parameter int RESP_TIMEOUT = 2048
) (
    input  logic                             mm_clk,
    input  logic                             rst_n,
    input  logic [NUM_MASTERS*ADDR_SIZE-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]           m_read,
    input  logic [NUM_MASTERS-1:0]           m_write,
    input  logic [NUM_MASTERS*32-1:0]        m_writedata,
    input  logic [NUM_MASTERS*4-1:0]         m_byteenable,
    output logic [NUM_MASTERS-1:0]           m_waitrequest,
    output logic [31:0]                      m_readdata,
    output logic [NUM_MASTERS-1:0]           m_readdatavalid,
    output logic [ADDR_SIZE-1:0]             s_address,
    output logic                             s_read,
    output logic                             s_write,
    output logic [31:0]                      s_writedata,
    output logic [3:0]                       s_byteenable,
    input  logic                             s_waitrequest,
    input  logic [31:0]                      s_readdata,
    input  logic                             s_readdatavalid,
    output logic [15:0]                      err_count
);
    localparam int GW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || RESP_TIMEOUT < 1 || RESP_TIMEOUT > 65536) begin : g_bad_cfg
        $error("mm_regs_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, CMD, RESP, REJECT} state_t;

    state_t                 state, state_nxt;
    logic [GW-1:0]          rr_ptr, grant, win, grant_inc;
    logic                   found, is_write, done, tmo;
    logic [NUM_MASTERS-1:0] req, rdv;
    logic [ADDR_SIZE-1:0]   addr_q, sel_addr;
    logic [31:0]            wdata_q, sel_data, readdata;
    logic [3:0]             sel_be;
    logic                   sel_wr;

    assign req = m_read | m_write;

    // Highest offset first so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        win   = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            idx = idx >= NUM_MASTERS ? idx - NUM_MASTERS : idx;
            if (req[GW'(idx)]) begin
                win   = GW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_be   = '0;
        sel_wr   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (GW'(k) == win) begin
                sel_addr = m_address[k*ADDR_SIZE +: ADDR_SIZE];
                sel_data = m_writedata[k*32 +: 32];
                sel_be   = m_byteenable[k*4 +: 4];
                sel_wr   = m_write[k];
            end
    end

    assign grant_inc = grant == GW'(NUM_MASTERS - 1) ? '0 : grant + 1'b1;

    always_comb begin
        state_nxt     = state;
        done          = 1'b0;
        m_waitrequest = '1;
        case (state)
            IDLE:   state_nxt = !found ? IDLE : (sel_wr && sel_be != 4'hF) ? REJECT : CMD;
            CMD: begin
                m_waitrequest[grant] = s_waitrequest;
                if (!s_waitrequest) begin
                    state_nxt = is_write ? IDLE : RESP;
                    done      = is_write;
                end
            end
            RESP: if (s_readdatavalid || tmo) begin
                state_nxt = IDLE;
                done      = 1'b1;
            end
            REJECT: begin
                m_waitrequest[grant] = 1'b0;
                state_nxt            = IDLE;
                done                 = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mm_clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_ff @(posedge mm_clk or negedge rst_n)
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant     <= '0;
            is_write  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            readdata  <= '0;
            rdv       <= '0;
            err_count <= '0;
        end else begin
            rdv <= '0;
            if (state == IDLE && found) begin
                grant    <= win;
                addr_q   <= sel_addr;
                wdata_q  <= sel_data;
                is_write <= sel_wr;
            end
            if (done) rr_ptr <= grant_inc;
            // Real data wins over a timeout landing on the same cycle.
            if (state == RESP && (s_readdatavalid || tmo)) begin
                readdata   <= s_readdatavalid ? s_readdata : 32'hDEAD_BEEF;
                rdv[grant] <= 1'b1;
            end
            if (state == REJECT && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
        end

`ifdef MM_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge mm_clk or negedge rst_n)
        if (!rst_n) tmo_cnt <= '0;
        else        tmo_cnt <= state == RESP ? tmo_cnt + 1'b1 : '0;

    assign tmo = state == RESP && tmo_cnt == 16'(RESP_TIMEOUT - 1);
`else
    assign tmo = 1'b0;
`endif

    assign s_read          = state == CMD && !is_write;
    assign s_write         = state == CMD && is_write;
    assign s_address       = addr_q;
    assign s_writedata     = wdata_q;
    assign s_byteenable    = 4'hF;
    assign m_readdata      = readdata;
    assign m_readdatavalid = rdv;
endmodule

// File: tb/tb_mm_regs_arbiter.sv
// tb_mm_regs_arbiter: directed checks of arbitration, partial-write rejection, reset abort and read timeout.
module tb_mm_regs_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  m_address;
    logic [1:0]  m_read, m_write;
    logic [63:0] m_writedata;
    logic [7:0]  m_byteenable;
    logic [1:0]  m_waitrequest, m_readdatavalid;
    logic [31:0] m_readdata;
    logic [3:0]  s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [15:0] err_count;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mm_regs_arbiter #(.NUM_MASTERS(2), .ADDR_SIZE(4), .RESP_TIMEOUT(16)) dut (
        .mm_clk(clk), .rst_n(rst_n),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int exp_g, nw, bad, found;
        logic [31:0] tmo_data;
        logic [1:0]  tmo_rdv;
        rst_n = 1'b0;
        m_address = '0; m_read = '0; m_write = '0; m_writedata = '0; m_byteenable = 8'hFF;
        s_waitrequest = 1'b1; s_readdata = '0; s_readdatavalid = 1'b0;
        #12;
        chk("rst_wreq", 32'(m_waitrequest), 'h3);
        chk("rst_rdv", 32'(m_readdatavalid), 'h0);
        chk("rst_rdata", m_readdata, 'h0);
        chk("rst_sread", 32'(s_read), 'h0);
        chk("rst_swrite", 32'(s_write), 'h0);
        chk("rst_saddr", 32'(s_address), 'h0);
        chk("rst_swdata", s_writedata, 'h0);
        chk("rst_sbe", 32'(s_byteenable), 'hF);
        chk("rst_err", 32'(err_count), 'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Master 0 read of address 3, bridge stalls five cycles
        m_read = 2'b01; m_address = 8'h03; s_waitrequest = 1'b1;
        #1;
        chk("rd_idle_wreq", 32'(m_waitrequest), 'h3);
        step;
        chk("rd_sread", 32'(s_read), 'h1);
        chk("rd_saddr", 32'(s_address), 'h3);
        chk("rd_stall_wreq", 32'(m_waitrequest), 'h3);
        repeat (4) step;
        s_waitrequest = 1'b0;
        #1;
        chk("rd_accept_wreq", 32'(m_waitrequest), 'h2);
        step;
        m_read = 2'b00; s_waitrequest = 1'b1;
        #1;
        chk("rd_resp_sread", 32'(s_read), 'h0);
        chk("rd_resp_wreq", 32'(m_waitrequest), 'h3);
        step; step;
        s_readdata = 32'h1234_5678; s_readdatavalid = 1'b1;
        step;
        s_readdatavalid = 1'b0;
        chk("rd_rdv", 32'(m_readdatavalid), 'h1);
        chk("rd_data", m_readdata, 32'h1234_5678);
        step;
        chk("rd_rdv_pulse", 32'(m_readdatavalid), 'h0);

        // Both masters write continuously from reset
        rst_n = 1'b0;
        m_write = 2'b11; m_address = 8'h95; m_writedata = {32'hB111_1111, 32'hA000_0000};
        s_waitrequest = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_g = 0; nw = 0;
        for (int c = 0; c < 8; c++) begin
            step;
            if (s_write) begin
                chk("rr_wreq", 32'(m_waitrequest), exp_g == 0 ? 'h2 : 'h1);
                chk("rr_data", s_writedata, exp_g == 0 ? 32'hA000_0000 : 32'hB111_1111);
                chk("rr_addr", 32'(s_address), exp_g == 0 ? 'h5 : 'h9);
                exp_g = 1 - exp_g;
                nw++;
            end
        end
        chk("rr_count", nw, 4);

        // Partial write from master 1 is rejected locally
        m_write = 2'b10; m_byteenable = 8'h3F; m_address = 8'h71;
        step;
        chk("rej_wreq", 32'(m_waitrequest), 'h1);
        chk("rej_swrite", 32'(s_write), 'h0);
        m_write = 2'b00; m_byteenable = 8'hFF;
        step;
        chk("rej_err", 32'(err_count), 'h1);
        chk("rej_done_wreq", 32'(m_waitrequest), 'h3);
        chk("rej_done_swrite", 32'(s_write), 'h0);
        m_write = 2'b01; m_writedata[31:0] = 32'hC0C0_C0C0;
        step;
        chk("post_rej_swrite", 32'(s_write), 'h1);
        chk("post_rej_data", s_writedata, 32'hC0C0_C0C0);
        chk("post_rej_addr", 32'(s_address), 'h1);
        chk("post_rej_wreq", 32'(m_waitrequest), 'h2);
        m_write = 2'b00;
        step;

        // Read and write together are a write
        m_read = 2'b01; m_write = 2'b01; m_address = 8'h42; m_writedata[31:0] = 32'hD00D_0002;
        step;
        chk("rw_swrite", 32'(s_write), 'h1);
        chk("rw_sread", 32'(s_read), 'h0);
        chk("rw_addr", 32'(s_address), 'h2);
        m_read = 2'b00; m_write = 2'b00;
        step;
        chk("rw_done_sread", 32'(s_read), 'h0);
        chk("rw_done_wreq", 32'(m_waitrequest), 'h3);

        // Reset while master 1 waits in RESP
        m_read = 2'b10;
        step;
        chk("rst_rd_wreq", 32'(m_waitrequest), 'h1);
        chk("rst_rd_sread", 32'(s_read), 'h1);
        m_read = 2'b00;
        step; step;
        rst_n = 1'b0;
        #1;
        chk("abort_err", 32'(err_count), 'h0);
        chk("abort_saddr", 32'(s_address), 'h0);
        chk("abort_wreq", 32'(m_waitrequest), 'h3);
        @(negedge clk);
        rst_n = 1'b1;
        s_readdata = 32'h5555_5555; s_readdatavalid = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            step;
            s_readdatavalid = 1'b0;
            if (m_readdatavalid !== 2'b00) bad++;
        end
        chk("abort_no_rdv", bad, 0);

`ifdef MM_ARB_TIMEOUT_EN
        // Bridge never answers: forced completion after 16 RESP cycles
        m_read = 2'b01; m_address = 8'h06;
        step;
        m_read = 2'b00;
        step;
        found = -1; tmo_data = '0; tmo_rdv = '0;
        for (int c = 1; c <= 40 && found < 0; c++) begin
            step;
            if (m_readdatavalid !== 2'b00) begin
                found = c; tmo_data = m_readdata; tmo_rdv = m_readdatavalid;
            end
        end
        chk("tmo_cycles", found, 16);
        chk("tmo_rdv", 32'(tmo_rdv), 'h1);
        chk("tmo_data", tmo_data, 32'hDEAD_BEEF);
        m_write = 2'b11;
        step;
        chk("tmo_next_grant", 32'(m_waitrequest), 'h1);
        m_write = 2'b00;
        step;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mm_regs_arbiter.md
Name: mm_regs_arbiter

Overview:
- Round-robin arbiter that shares one register-bridge Avalon-MM slave port between NUM_MASTERS Avalon-MM masters, for example the HPS lightweight bridge and an on-chip capture sequencer.
- One transaction is in flight at a time. The downstream bridge requires full-word writes, so the arbiter terminates partial writes locally; otherwise they would deadlock the bridge.
- Sits in the mm_clk domain, directly in front of the register bridge.

Parameters:
- NUM_MASTERS, 2, number of upstream masters (2..8).
- ADDR_SIZE, 4, word-address width, the same as the bridge.
- RESP_TIMEOUT, 2048, number of cycles in RESP before a forced completion (used only with the optional feature).

Ports:
- mm_clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- m_address  in  NUM_MASTERS*ADDR_SIZE  per-master address; master k uses slice [k*ADDR_SIZE +: ADDR_SIZE].
- m_read  in  NUM_MASTERS  per-master read request.
- m_write  in  NUM_MASTERS  per-master write request.
- m_writedata  in  NUM_MASTERS*32  per-master write data.
- m_byteenable  in  NUM_MASTERS*4  per-master byte enables.
- m_waitrequest  out  NUM_MASTERS  per-master waitrequest.
- m_readdata  out  32  shared read data, qualified by m_readdatavalid.
- m_readdatavalid  out  NUM_MASTERS  per-master read-data-valid strobe.
- s_address  out  ADDR_SIZE  downstream address.
- s_read  out  1  downstream read.
- s_write  out  1  downstream write.
- s_writedata  out  32  downstream write data.
- s_byteenable  out  4  downstream byte enables; always 4'b1111.
- s_waitrequest  in  1  downstream waitrequest.
- s_readdata  in  32  downstream read data.
- s_readdatavalid  in  1  downstream read-data-valid.
- err_count  out  16  saturating count of rejected partial writes.

Behaviour:
- Reset values: state=IDLE; rr_ptr=0; grant=0; m_waitrequest all 1; m_readdatavalid 0; m_readdata 0; s_read/s_write 0; s_address 0; s_writedata 0; err_count 0.
- A reset asserted mid-transaction aborts the transaction immediately. No response is generated afterwards.
- States are IDLE, CMD, RESP and REJECT.
- IDLE, master selection:
  - A master is requesting when m_read[k] or m_write[k] is high.
  - The winner is the first requesting index searching upward from rr_ptr, with wrap-around.
  - On the next edge the arbiter latches grant, address, writedata and is_write. If a master asserts both read and write, it is treated as a write.
- IDLE, next state:
  - Partial write (byteenable != 4'b1111) goes to REJECT.
  - Any other request goes to CMD.
  - No request stays in IDLE.
- CMD:
  - s_read or s_write is driven from the latched command.
  - m_waitrequest[grant] = s_waitrequest (combinational), so the master completes its command in the same cycle the bridge accepts it.
  - When s_waitrequest is low: a write goes to IDLE; a read goes to RESP.
  - s_read and s_write drop on the cycle after acceptance.
- RESP:
  - On s_readdatavalid, m_readdata is registered from s_readdata.
  - m_readdatavalid[grant] pulses high for exactly one cycle, one cycle after s_readdatavalid.
  - State goes to IDLE on the same edge.
  - Without the optional feature, RESP waits indefinitely.
- REJECT:
  - Lasts one cycle with m_waitrequest[grant]=0. The downstream bus stays idle.
  - err_count increments, saturating at 16'hFFFF.
  - State goes to IDLE.
- rr_ptr is set to (grant+1) mod NUM_MASTERS on every transaction completion: write accepted, read data returned, reject, or timeout.
- Masters that are not granted always see waitrequest=1 and readdatavalid=0.
- Minimum transaction latency from request to the first CMD cycle is 1 cycle. Back-to-back grants need at least one IDLE cycle between them.
- A master that deasserts its request while waiting is a protocol violation. The latched command is completed regardless.

Optional Feature:
- Macro: MM_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to RESP and increments each cycle in RESP.
  - On reaching RESP_TIMEOUT, the arbiter returns m_readdata=32'hDEAD_BEEF with m_readdatavalid[grant]=1, advances rr_ptr, and goes to IDLE.
  - A late s_readdatavalid arriving while in IDLE is ignored.
- When undefined: no counter is present and RESP waits indefinitely.

Test Plan:
- Single master 0 reads address 3; bridge accepts after 5 cycles and returns 32'h1234_5678 -> m_waitrequest[0] low for 1 cycle; m_readdatavalid[0] one cycle after s_readdatavalid with data 32'h1234_5678; m_readdatavalid[1] stays 0.
- Masters 0 and 1 both write continuously from reset -> grants alternate 0,1,0,1. Each s_write carries the data of the granted master. No master is starved.
- Master 1 writes with byteenable 4'b0011 -> s_write never asserts; m_waitrequest[1] low for 1 cycle; err_count=1. The next request is granted normally.
- Master 0 asserts read and write together to address 2 -> a single s_write to address 2, with no s_read.
- Reset asserted during RESP -> all outputs return to reset values asynchronously. No m_readdatavalid is seen after reset is released.
- With MM_ARB_TIMEOUT_EN and RESP_TIMEOUT=16, the bridge never returns data -> after 16 RESP cycles, m_readdatavalid[grant]=1 with 32'hDEAD_BEEF, and the next master is granted.
